// File: rtl/m14k_udi_pkg.sv
// Shared definitions for the m14k UDI master: the SPECIAL2 opcode, UDI funct codes, the
// controller state encoding, the response status encoding and an instruction-word builder.
package m14k_udi_pkg;

  localparam logic [5:0] OpSpecial2  = 6'b011100;

  localparam logic [5:0] FunctSwpmfh = 6'b010010;
  localparam logic [5:0] FunctSwpmfl = 6'b010011;
  localparam logic [5:0] FunctSwpmt  = 6'b010100;
  localparam logic [5:0] FunctSwp    = 6'b010101;
  localparam logic [5:0] FunctSwpacc = 6'b010110;
  localparam logic [5:0] FunctSwpgpr = 6'b010111;

  typedef enum logic [1:0] {
    StIdle,
    StE,
    StM,
    StResp
  } udi_state_e;

  typedef enum logic [1:0] {
    RspOk,
    RspRi,
    RspKilled,
    RspTimeout
  } rsp_status_e;

  function automatic logic [31:0] build_ir(input logic [5:0] funct, input logic [4:0] rd);
    return {OpSpecial2, 10'b0, rd, 5'b0, funct};
  endfunction

endpackage

// File: rtl/m14k_udi_master_if.sv
// Bundles the command channel, the response channel and the core-side UDI port signals.
// master: the m14k_udi_master controller. slave: the command source plus the UDI module.
interface m14k_udi_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_funct;
  logic [4:0]  cmd_rd;
  logic [31:0] cmd_rs;
  logic [31:0] cmd_rt;
  logic        cmd_kill;
  logic        cmd_kd;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_wrreg;
  logic        rsp_ri;
  logic        rsp_killed;
  logic        rsp_timeout;

  logic [31:0] UDI_ir_e;
  logic        UDI_irvalid_e;
  logic        UDI_start_e;
  logic [31:0] UDI_rs_e;
  logic [31:0] UDI_rt_e;
  logic        UDI_endianb_e;
  logic        UDI_kd_mode_e;
  logic        UDI_run_m;
  logic        UDI_kill_m;
  logic [31:0] UDI_rd_m;
  logic [4:0]  UDI_wrreg_e;
  logic        UDI_ri_e;
  logic        UDI_stall_m;
  logic        UDI_present;

  modport master (
    input  cmd_valid, cmd_funct, cmd_rd, cmd_rs, cmd_rt, cmd_kill, cmd_kd, rsp_ready,
    input  UDI_rd_m, UDI_wrreg_e, UDI_ri_e, UDI_stall_m, UDI_present,
    output cmd_ready, rsp_valid, rsp_data, rsp_wrreg, rsp_ri, rsp_killed, rsp_timeout,
    output UDI_ir_e, UDI_irvalid_e, UDI_start_e, UDI_rs_e, UDI_rt_e, UDI_endianb_e,
    output UDI_kd_mode_e, UDI_run_m, UDI_kill_m
  );

  modport slave (
    output cmd_valid, cmd_funct, cmd_rd, cmd_rs, cmd_rt, cmd_kill, cmd_kd, rsp_ready,
    output UDI_rd_m, UDI_wrreg_e, UDI_ri_e, UDI_stall_m, UDI_present,
    input  cmd_ready, rsp_valid, rsp_data, rsp_wrreg, rsp_ri, rsp_killed, rsp_timeout,
    input  UDI_ir_e, UDI_irvalid_e, UDI_start_e, UDI_rs_e, UDI_rt_e, UDI_endianb_e,
    input  UDI_kd_mode_e, UDI_run_m, UDI_kill_m
  );

endinterface

// File: rtl/m14k_udi_stall_wdog.sv
// Saturating 8-bit M-stage stall counter.
//   clk_i, rst_i : clock and synchronous active-high reset
//   clr_i        : restart the count from zero (has priority over en_i)
//   en_i         : count one stalled cycle
//   expired_o    : count has reached MaxCnt
module m14k_udi_stall_wdog #(
  parameter int unsigned MaxCnt = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] Limit = 8'(MaxCnt);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == Limit);

endmodule

// File: rtl/m14k_udi_master.sv
// Command-driven initiator for the m14k UDI port. Accepts one command, drives the E-stage
// and M-stage UDI signals as the core pipeline would, and returns the result.
//   UDI_gclk   : clock
//   UDI_greset : synchronous active-high reset; discards any command in flight
//   bus        : command channel, response channel and UDI port (master modport)
module m14k_udi_master
  import m14k_udi_pkg::*;
#(
  parameter bit          ENDIAN_BIG = 1'b0,
  parameter int unsigned STALL_MAX  = 15
) (
  input logic                UDI_gclk,
  input logic                UDI_greset,
  m14k_udi_master_if.master  bus
);

  udi_state_e  state_q, state_d;
  rsp_status_e status_q, status_d;
  logic [5:0]  funct_q, funct_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rs_q, rs_d, rt_q, rt_d;
  logic        kill_q, kill_d, kd_q, kd_d;
  logic [4:0]  wrreg_q, wrreg_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [4:0]  rsp_wrreg_q, rsp_wrreg_d;
  logic        wd_clr, wd_en, wd_expired;

  m14k_udi_stall_wdog #(
    .MaxCnt(STALL_MAX)
  ) u_wdog (
    .clk_i    (UDI_gclk),
    .rst_i    (UDI_greset),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    funct_d     = funct_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    kill_d      = kill_q;
    kd_d        = kd_q;
    wrreg_d     = wrreg_q;
    rsp_data_d  = rsp_data_q;
    rsp_wrreg_d = rsp_wrreg_q;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;

    bus.cmd_ready     = 1'b0;
    bus.UDI_ir_e      = 32'd0;
    bus.UDI_irvalid_e = 1'b0;
    bus.UDI_start_e   = 1'b0;
    bus.UDI_run_m     = 1'b0;
    bus.UDI_kill_m    = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          funct_d     = bus.cmd_funct;
          rd_d        = bus.cmd_rd;
          rs_d        = bus.cmd_rs;
          rt_d        = bus.cmd_rt;
          kill_d      = bus.cmd_kill;
          kd_d        = bus.cmd_kd;
          wrreg_d     = 5'd0;
          rsp_data_d  = 32'd0;
          rsp_wrreg_d = 5'd0;
          status_d    = bus.UDI_present ? RspOk : RspRi;
          state_d     = bus.UDI_present ? StE : StResp;
        end
      end
      StE: begin
        bus.UDI_ir_e      = build_ir(funct_q, rd_q);
        bus.UDI_irvalid_e = 1'b1;
        bus.UDI_start_e   = 1'b1;
        wd_clr            = 1'b1;
        if (bus.UDI_ri_e) begin
          status_d = RspRi;
          state_d  = StResp;
        end else begin
          wrreg_d = bus.UDI_wrreg_e;
          state_d = StM;
        end
      end
      StM: begin
        if (wd_expired) begin
          // Stalled too long: retire the instruction as killed so the UDI module unwinds.
          bus.UDI_run_m  = 1'b1;
          bus.UDI_kill_m = 1'b1;
          status_d       = RspTimeout;
          state_d        = StResp;
        end else if (bus.UDI_stall_m) begin
          wd_en = 1'b1;
        end else begin
          bus.UDI_run_m  = 1'b1;
          bus.UDI_kill_m = kill_q;
          rsp_data_d     = ((wrreg_q != 5'd0) && !kill_q) ? bus.UDI_rd_m : 32'd0;
          rsp_wrreg_d    = kill_q ? 5'd0 : wrreg_q;
          status_d       = kill_q ? RspKilled : RspOk;
          state_d        = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge UDI_gclk) begin
    if (UDI_greset) begin
      state_q     <= StIdle;
      status_q    <= RspOk;
      funct_q     <= 6'd0;
      rd_q        <= 5'd0;
      rs_q        <= 32'd0;
      rt_q        <= 32'd0;
      kill_q      <= 1'b0;
      kd_q        <= 1'b0;
      wrreg_q     <= 5'd0;
      rsp_data_q  <= 32'd0;
      rsp_wrreg_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      funct_q     <= funct_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      kill_q      <= kill_d;
      kd_q        <= kd_d;
      wrreg_q     <= wrreg_d;
      rsp_data_q  <= rsp_data_d;
      rsp_wrreg_q <= rsp_wrreg_d;
    end
  end

  // Operands stay on the UDI port from E until the response is taken; zero when idle.
  always_comb begin
    bus.UDI_endianb_e = ENDIAN_BIG;
    bus.UDI_rs_e      = (state_q != StIdle) ? rs_q : 32'd0;
    bus.UDI_rt_e      = (state_q != StIdle) ? rt_q : 32'd0;
    bus.UDI_kd_mode_e = (state_q != StIdle) ? kd_q : 1'b0;
    bus.rsp_valid     = (state_q == StResp);
    bus.rsp_data      = bus.rsp_valid ? rsp_data_q : 32'd0;
    bus.rsp_wrreg     = bus.rsp_valid ? rsp_wrreg_q : 5'd0;
    bus.rsp_ri        = bus.rsp_valid && (status_q == RspRi);
    bus.rsp_killed    = bus.rsp_valid && (status_q == RspKilled);
    bus.rsp_timeout   = bus.rsp_valid && (status_q == RspTimeout);
  end

endmodule

// File: tb/tb_m14k_udi_master.sv
module tb_m14k_udi_master;
  import m14k_udi_pkg::*;

  localparam int unsigned StallMax = 4;

  typedef struct {
    int          lat;
    int          kill_lat;
    int          t_acc;
    bit          saw_run;
    bit          changed;
    logic [31:0] ir;
    logic [31:0] rs_e;
    logic        kd;
    logic        irvalid;
    logic        start;
    logic [31:0] data;
    logic [4:0]  wrreg;
    logic        ri;
    logic        killed;
    logic        to;
    logic        valid_after;
  } obs_t;

  logic clk = 1'b0;
  logic greset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  m14k_udi_master_if bus ();

  m14k_udi_master #(
    .ENDIAN_BIG(1'b1),
    .STALL_MAX (StallMax)
  ) dut (
    .UDI_gclk  (clk),
    .UDI_greset(greset),
    .bus       (bus)
  );

  // Small UDI module model: HI/LO pair, one stall cycle for reads, commit after run.
  logic        udi_present = 1'b1;
  logic        force_stall = 1'b0;
  logic [31:0] hi_q = 32'd0, lo_q = 32'd0, m_rs_q = 32'd0, m_rt_q = 32'd0;
  logic [5:0]  m_funct_q = 6'd0;
  logic        pend_stall_q = 1'b0;
  logic [5:0]  e_funct;
  logic [4:0]  e_rd;
  logic        e_is_read, e_known;

  assign e_funct   = bus.UDI_ir_e[5:0];
  assign e_rd      = bus.UDI_ir_e[15:11];
  assign e_is_read = (e_funct == FunctSwpmfh) || (e_funct == FunctSwpmfl) ||
                     (e_funct == FunctSwpgpr);
  assign e_known   = (e_funct >= FunctSwpmfh) && (e_funct <= FunctSwpgpr);

  assign bus.UDI_present = udi_present;
  assign bus.UDI_ri_e    = !e_known;
  assign bus.UDI_wrreg_e = e_is_read ? e_rd : 5'd0;
  assign bus.UDI_stall_m = force_stall | pend_stall_q;
  assign bus.UDI_rd_m    = (m_funct_q == FunctSwpmfh) ? hi_q :
                           (m_funct_q == FunctSwpmfl) ? lo_q :
                           (m_funct_q == FunctSwpgpr) ? (m_rs_q ^ m_rt_q) : 32'd0;

  always @(posedge clk) begin
    if (bus.UDI_start_e) begin
      m_funct_q    <= e_funct;
      m_rs_q       <= bus.UDI_rs_e;
      m_rt_q       <= bus.UDI_rt_e;
      pend_stall_q <= e_is_read;
    end else begin
      pend_stall_q <= 1'b0;
    end
    if (bus.UDI_run_m && !bus.UDI_kill_m && !bus.UDI_stall_m) begin
      if (m_funct_q == FunctSwpmt) begin
        hi_q <= m_rs_q;
        lo_q <= m_rt_q;
      end else if (m_funct_q == FunctSwp) begin
        hi_q <= {m_rt_q[31:16], m_rs_q[31:16]};
        lo_q <= {m_rt_q[15:0], m_rs_q[15:0]};
      end
    end
  end

  // Issues one command (called at a negedge), follows it to its response, holds rsp_ready
  // low for 'hold' extra cycles, then consumes it. Returns to the caller at a negedge.
  task automatic run_cmd(input logic [5:0] funct, input logic [4:0] rd, input logic [31:0] rs,
                         input logic [31:0] rt, input logic kill, input logic kd,
                         input int hold, output obs_t o);
    int n;
    o = '{lat: 0, kill_lat: -1, t_acc: 0, saw_run: 0, changed: 0, ir: 0, rs_e: 0, kd: 0,
          irvalid: 0, start: 0, data: 0, wrreg: 0, ri: 0, killed: 0, to: 0, valid_after: 0};
    bus.cmd_funct = funct;
    bus.cmd_rd    = rd;
    bus.cmd_rs    = rs;
    bus.cmd_rt    = rt;
    bus.cmd_kill  = kill;
    bus.cmd_kd    = kd;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    o.t_acc = cyc;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    while (1) begin
      @(negedge clk);
      o.lat++;
      if (o.lat == 1) begin
        o.ir      = bus.UDI_ir_e;
        o.rs_e    = bus.UDI_rs_e;
        o.kd      = bus.UDI_kd_mode_e;
        o.irvalid = bus.UDI_irvalid_e;
        o.start   = bus.UDI_start_e;
      end
      if (bus.UDI_run_m) o.saw_run = 1;
      if (bus.UDI_kill_m && o.kill_lat < 0) o.kill_lat = o.lat;
      if (bus.rsp_valid || o.lat > 50) break;
    end
    o.data   = bus.rsp_data;
    o.wrreg  = bus.rsp_wrreg;
    o.ri     = bus.rsp_ri;
    o.killed = bus.rsp_killed;
    o.to     = bus.rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== o.data || bus.rsp_wrreg !== o.wrreg ||
          bus.rsp_ri !== o.ri || bus.rsp_killed !== o.killed || bus.rsp_timeout !== o.to)
        o.changed = 1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    o.valid_after = bus.rsp_valid;
  endtask

  task automatic test_reset();
    greset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.UDI_ir_e !== 32'd0) begin bad++; $display("FAIL reset_ir got=%h exp=0", bus.UDI_ir_e); end
    total++; if ({bus.UDI_run_m, bus.UDI_kill_m, bus.UDI_start_e} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b exp=000", {bus.UDI_run_m, bus.UDI_kill_m, bus.UDI_start_e}); end
    total++; if (bus.UDI_endianb_e !== 1'b1) begin bad++; $display("FAIL reset_endian got=%b exp=1", bus.UDI_endianb_e); end
    greset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_swpmt_mfh();
    obs_t o;
    run_cmd(FunctSwpmt, 5'd0, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b1, 0, o);
    total++; if (o.lat !== 3) begin bad++; $display("FAIL swpmt_latency got=%0d exp=3", o.lat); end
    total++; if (o.ir !== 32'h7000_0014) begin bad++; $display("FAIL swpmt_ir got=%h exp=70000014", o.ir); end
    total++; if ({o.irvalid, o.start, o.kd} !== 3'b111) begin bad++; $display("FAIL swpmt_e_ctl got=%b exp=111", {o.irvalid, o.start, o.kd}); end
    total++; if (o.rs_e !== 32'h1111_2222) begin bad++; $display("FAIL swpmt_rs_e got=%h exp=11112222", o.rs_e); end
    total++; if ({o.ri, o.killed, o.to, o.data, o.wrreg} !== 40'd0) begin bad++; $display("FAIL swpmt_rsp got=%b%b%b %h %0d exp=all zero", o.ri, o.killed, o.to, o.data, o.wrreg); end
    total++; if (o.valid_after !== 1'b0) begin bad++; $display("FAIL swpmt_release got=%b exp=0", o.valid_after); end
    run_cmd(FunctSwpmfh, 5'd2, 32'd0, 32'd0, 1'b0, 1'b0, 0, o);
    total++; if (o.lat !== 4) begin bad++; $display("FAIL swpmfh_latency got=%0d exp=4", o.lat); end
    total++; if (o.ir !== 32'h7000_1012) begin bad++; $display("FAIL swpmfh_ir got=%h exp=70001012", o.ir); end
    total++; if (o.data !== 32'h1111_2222) begin bad++; $display("FAIL swpmfh_data got=%h exp=11112222", o.data); end
    total++; if (o.wrreg !== 5'd2) begin bad++; $display("FAIL swpmfh_wrreg got=%0d exp=2", o.wrreg); end
  endtask

  task automatic test_swp_mfl_hold();
    obs_t o;
    run_cmd(FunctSwp, 5'd0, 32'hAAAA_BBBB, 32'hCCCC_DDDD, 1'b0, 1'b0, 0, o);
    total++; if (o.lat !== 3) begin bad++; $display("FAIL swp_latency got=%0d exp=3", o.lat); end
    run_cmd(FunctSwpmfl, 5'd5, 32'd0, 32'd0, 1'b0, 1'b0, 5, o);
    total++; if (o.data !== 32'hDDDD_BBBB) begin bad++; $display("FAIL swpmfl_data got=%h exp=ddddbbbb", o.data); end
    total++; if (o.wrreg !== 5'd5) begin bad++; $display("FAIL swpmfl_wrreg got=%0d exp=5", o.wrreg); end
    total++; if (o.changed !== 1'b0) begin bad++; $display("FAIL resp_hold_stable got=%b exp=0", o.changed); end
  endtask

  task automatic test_ri();
    obs_t o;
    run_cmd(6'b000000, 5'd7, 32'h1, 32'h2, 1'b0, 1'b0, 0, o);
    total++; if (o.lat !== 2) begin bad++; $display("FAIL ri_latency got=%0d exp=2", o.lat); end
    total++; if ({o.ri, o.killed, o.to} !== 3'b100) begin bad++; $display("FAIL ri_flags got=%b exp=100", {o.ri, o.killed, o.to}); end
    total++; if (o.saw_run !== 1'b0) begin bad++; $display("FAIL ri_no_run got=%b exp=0", o.saw_run); end
    total++; if ({o.wrreg, o.data} !== 37'd0) begin bad++; $display("FAIL ri_fields got=%0d %h exp=0 0", o.wrreg, o.data); end
    udi_present = 1'b0;
    run_cmd(FunctSwpmfh, 5'd3, 32'd0, 32'd0, 1'b0, 1'b0, 0, o);
    udi_present = 1'b1;
    total++; if (o.lat !== 1) begin bad++; $display("FAIL absent_latency got=%0d exp=1", o.lat); end
    total++; if ({o.ri, o.saw_run, o.irvalid} !== 3'b100) begin bad++; $display("FAIL absent_flags got=%b exp=100", {o.ri, o.saw_run, o.irvalid}); end
  endtask

  task automatic test_kill();
    obs_t o;
    run_cmd(FunctSwpmt, 5'd0, 32'h5555_6666, 32'h7777_8888, 1'b1, 1'b0, 0, o);
    total++; if (o.kill_lat !== 2) begin bad++; $display("FAIL kill_pulse_at got=%0d exp=2", o.kill_lat); end
    total++; if ({o.ri, o.killed, o.to} !== 3'b010) begin bad++; $display("FAIL kill_flags got=%b exp=010", {o.ri, o.killed, o.to}); end
    total++; if (o.lat !== 3) begin bad++; $display("FAIL kill_latency got=%0d exp=3", o.lat); end
    run_cmd(FunctSwpmfh, 5'd4, 32'd0, 32'd0, 1'b0, 1'b0, 0, o);
    total++; if (o.data !== 32'hCCCC_AAAA) begin bad++; $display("FAIL kill_hi_kept got=%h exp=ccccaaaa", o.data); end
  endtask

  task automatic test_timeout();
    obs_t o;
    force_stall = 1'b1;
    run_cmd(FunctSwpmfh, 5'd6, 32'd0, 32'd0, 1'b0, 1'b0, 0, o);
    force_stall = 1'b0;
    total++; if (o.kill_lat !== 6) begin bad++; $display("FAIL timeout_kill_at got=%0d exp=6", o.kill_lat); end
    total++; if (o.lat !== 7) begin bad++; $display("FAIL timeout_latency got=%0d exp=7", o.lat); end
    total++; if ({o.ri, o.killed, o.to} !== 3'b001) begin bad++; $display("FAIL timeout_flags got=%b exp=001", {o.ri, o.killed, o.to}); end
    total++; if ({o.data, o.wrreg} !== 37'd0) begin bad++; $display("FAIL timeout_fields got=%h %0d exp=0 0", o.data, o.wrreg); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.cmd_funct = FunctSwpmfh;
    bus.cmd_rd    = 5'd1;
    bus.cmd_rs    = 32'hDEAD_BEEF;
    bus.cmd_rt    = 32'h1234_5678;
    bus.cmd_kill  = 1'b0;
    bus.cmd_kd    = 1'b1;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.UDI_rs_e !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mid_in_m_rs got=%h exp=deadbeef", bus.UDI_rs_e); end
    greset = 1'b1;
    @(negedge clk);
    greset = 1'b0;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got=%b exp=1", bus.cmd_ready); end
    total++; if ({bus.UDI_rs_e, bus.UDI_rt_e, bus.UDI_ir_e} !== 96'd0) begin bad++; $display("FAIL mid_reset_data got=%h %h %h exp=0", bus.UDI_rs_e, bus.UDI_rt_e, bus.UDI_ir_e); end
    total++; if ({bus.UDI_run_m, bus.UDI_kill_m, bus.UDI_kd_mode_e, bus.rsp_valid} !== 4'b0000) begin bad++; $display("FAIL mid_reset_ctl got=%b exp=0000", {bus.UDI_run_m, bus.UDI_kill_m, bus.UDI_kd_mode_e, bus.rsp_valid}); end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_reset_no_rsp got=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    obs_t a, b;
    run_cmd(FunctSwpmt, 5'd0, 32'h0BAD_F00D, 32'hFACE_0001, 1'b0, 1'b0, 0, a);
    run_cmd(FunctSwpmfl, 5'd9, 32'd0, 32'd0, 1'b0, 1'b0, 0, b);
    total++; if (b.t_acc - a.t_acc !== 4) begin bad++; $display("FAIL b2b_spacing got=%0d exp=4", b.t_acc - a.t_acc); end
    total++; if (b.data !== 32'hFACE_0001) begin bad++; $display("FAIL b2b_data got=%h exp=face0001", b.data); end
    total++; if (b.wrreg !== 5'd9) begin bad++; $display("FAIL b2b_wrreg got=%0d exp=9", b.wrreg); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_funct = 6'd0;
    bus.cmd_rd    = 5'd0;
    bus.cmd_rs    = 32'd0;
    bus.cmd_rt    = 32'd0;
    bus.cmd_kill  = 1'b0;
    bus.cmd_kd    = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_swpmt_mfh();
    test_swp_mfl_hold();
    test_ri();
    test_kill();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
